// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// state encoding, datapath width, iteration count, fixed latencies and
// the Booth recoding pairs.
package multdiv_pkg;

  localparam int unsigned MD_WIDTH      = 32;
  localparam int unsigned ITER          = 32;
  localparam int unsigned MD_MUL_CYCLES = ITER + 1;  // 32 Booth steps + DONE
  localparam int unsigned MD_DIV_CYCLES = ITER + 4;  // |A|, |B|, 32 steps, fix, DONE
  localparam int unsigned CNT_W         = 6;

  // {Q[0], q_1} recoding
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL      = 3'd1,
    S_DIV_NEGA = 3'd2,
    S_DIV_NEGB = 3'd3,
    S_DIV      = 3'd4,
    S_DIV_FIX  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/multdiv_seq_booth_select.sv
// Radix-2 Booth operand selection for the shared adder.
//   pair  : {Q[0], q_1} recoding bits
//   m     : multiplicand
//   a_msb : sign bit of the adder A operand (ACC)
//   cout  : carry out of the shared adder
//   b/cin : adder B operand and carry in (+M, -M or +0)
//   ext   : true 33rd bit of ACC +/- M, so M = 0x80000000 stays exact
module booth_select
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [1:0]       pair,
  input  logic [WIDTH-1:0] m,
  input  logic             a_msb,
  input  logic             cout,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  output logic             ext
);

  always_comb begin
    b   = '0;
    cin = 1'b0;
    case (pair)
      BOOTH_ADD: b = m;
      BOOTH_SUB: begin
        b   = ~m;
        cin = 1'b1;
      end
      default: ;
    endcase
    // sign of the sign-extended 33-bit sum
    ext = a_msb ^ b[WIDTH-1] ^ cout;
  end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes) sequencer driving one external shared adder per cycle.
//   clock, reset_n          : clock, async active-low reset
//   ctrl_MULT, ctrl_DIV     : start pulses (MULT wins when both high)
//   data_operandA/B         : operands, latched on a start edge
//   adder_a/b/cin           : shared adder inputs (0 when idle/done)
//   adder_sum/cout          : shared adder result, same cycle
//   data_result/exception   : result, held until next start or reset
//   data_resultRDY          : one-cycle completion pulse (state DONE)
//   busy                    : high while not IDLE
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH      = MD_WIDTH,
  parameter int unsigned MUL_CYCLES = MD_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = MD_DIV_CYCLES
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 5);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  // acc: Booth ACC / division remainder R
  // q  : Booth Q / B during DIV_NEGA / dividend-quotient Dd
  // m  : multiplicand / A during DIV_NEGA / |B| afterwards
  logic [WIDTH-1:0] acc, q, m;
  logic             q_1;
  logic [CNT_W-1:0] cnt;
  logic             sign_a, sign_b, b_zero, ovf;

  logic             start;
  logic [WIDTH-1:0] booth_b;
  logic             booth_cin, ext;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH:0]   mul_hi;

  assign start  = ctrl_MULT | ctrl_DIV;
  assign r_sh   = {acc[WIDTH-2:0], q[WIDTH-1]};
  // product[63:31] after the final shift is exactly {ext, adder_sum}
  assign mul_hi = {ext, adder_sum};

  assign data_resultRDY = (state == S_DONE);
  assign busy           = (state != S_IDLE);

  booth_select #(.WIDTH(WIDTH)) u_booth (
    .pair  ({q[0], q_1}),
    .m     (m),
    .a_msb (acc[WIDTH-1]),
    .cout  (adder_cout),
    .b     (booth_b),
    .cin   (booth_cin),
    .ext   (ext)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    case (state)
      S_IDLE: ;
      S_MUL: begin
        adder_a   = acc;
        adder_b   = booth_b;
        adder_cin = booth_cin;
        if (cnt == MUL_LAST) state_nxt = S_DONE;
      end
      S_DIV_NEGA: begin
        adder_b   = sign_a ? ~m : m;
        adder_cin = sign_a;
        state_nxt = S_DIV_NEGB;
      end
      S_DIV_NEGB: begin
        adder_b   = sign_b ? ~m : m;
        adder_cin = sign_b;
        state_nxt = S_DIV;
      end
      S_DIV: begin
        adder_a   = r_sh;
        adder_b   = ~m;
        adder_cin = 1'b1;
        if (cnt == DIV_LAST) state_nxt = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        if (sign_a ^ sign_b) begin
          adder_b   = ~q;
          adder_cin = 1'b1;
        end else begin
          adder_a = q;
        end
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (start) state_nxt = ctrl_MULT ? S_MUL : S_DIV_NEGA;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc            <= '0;
      q              <= '0;
      m              <= '0;
      q_1            <= 1'b0;
      cnt            <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      b_zero         <= 1'b0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      q      <= data_operandB;
      m      <= data_operandA;
      q_1    <= 1'b0;
      cnt    <= '0;
      sign_a <= data_operandA[WIDTH-1];
      sign_b <= data_operandB[WIDTH-1];
      b_zero <= (data_operandB == '0);
      ovf    <= (data_operandA == MIN_NEG) && (data_operandB == '1);
    end else begin
      case (state)
        S_MUL: begin
          {acc, q, q_1} <= {ext, adder_sum, q};
          cnt           <= cnt + 1'b1;
          if (cnt == MUL_LAST) begin
            data_result    <= {adder_sum[0], q[WIDTH-1:1]};
            data_exception <= ~((&mul_hi) | ~(|mul_hi));
          end
        end
        // |A| goes to Dd while B moves into m for the next cycle
        S_DIV_NEGA: begin
          q <= adder_sum;
          m <= q;
        end
        S_DIV_NEGB: m <= adder_sum;
        S_DIV: begin
          cnt <= cnt + 1'b1;
          if (adder_cout) begin
            acc <= adder_sum;
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            acc <= r_sh;
            q   <= {q[WIDTH-2:0], 1'b0};
          end
        end
        S_DIV_FIX: begin
          data_result    <= b_zero ? '0 : adder_sum;
          data_exception <= b_zero | ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: hand-derived vector table,
// randomized operations against a plain-arithmetic reference model, and
// hand-written abort / dual-start / async-reset sequences.
// "RDY at edge N" is observed on the falling edge just before rising
// edge N, counting the start edge as edge 0.
module tb_multdiv_seq;

  localparam int MUL_LAT = 33;
  localparam int DIV_LAT = 36;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] adder_a, adder_b, adder_sum;
  logic        adder_cin, adder_cout;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  logic [32:0] add_full;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // external shared adder
  assign add_full   = {1'b0, adder_a} + {1'b0, adder_b} + {32'd0, adder_cin};
  assign adder_sum  = add_full[31:0];
  assign adder_cout = add_full[32];

  multdiv_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .adder_a        (adder_a),
    .adder_b        (adder_b),
    .adder_cin      (adder_cin),
    .adder_sum      (adder_sum),
    .adder_cout     (adder_cout),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  typedef struct {
    bit          is_mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    string       name;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int     sa, sb;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      sa = a;
      sb = b;
      r  = sa / sb;
      e  = 1'b0;
    end
  endfunction

  task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // called right after the start edge; watches edges 1..lat+3
  task automatic wait_rdy(input int lat, input logic [31:0] er, input logic ee, input string nm);
    int          first  = -1;
    int          pulses = 0;
    bit          busy_ok = 1'b1;
    logic [31:0] got_res = '0;
    logic        got_exc = 1'b0;
    logic [31:0] hold_res = '0;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clock);
      if (k <= lat && busy !== 1'b1) busy_ok = 1'b0;
      if (k == lat + 1 && busy !== 1'b0) busy_ok = 1'b0;
      if (k == lat + 2) hold_res = data_result;
      if (data_resultRDY === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first   = k;
          got_res = data_result;
          got_exc = data_exception;
        end
      end
    end
    check($sformatf("%s.latency", nm), 32'(first), 32'(lat));
    check($sformatf("%s.pulses", nm), 32'(pulses), 32'd1);
    check($sformatf("%s.result", nm), got_res, er);
    check($sformatf("%s.exception", nm), {31'd0, got_exc}, {31'd0, ee});
    check($sformatf("%s.busy", nm), {31'd0, busy_ok}, 32'd1);
    check($sformatf("%s.hold", nm), hold_res, er);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] er, ra, rb;
    logic        ee;
    bit          rm, no_rdy, no_busy;

    vecs.push_back('{1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_x_m3"});
    vecs.push_back('{1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, "mul_min_x_1"});
    vecs.push_back('{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_x_m1"});
    vecs.push_back('{1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_2p16_sq"});
    vecs.push_back('{1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "mul_min_sq"});
    vecs.push_back('{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_m1_sq"});
    vecs.push_back('{0, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, "div_m100_7"});
    vecs.push_back('{0, 32'd100,       32'd0,         32'h0000_0000, 1'b1, "div_by_zero"});
    vecs.push_back('{0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_min_m1"});
    vecs.push_back('{0, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0, "div_min_2"});
    vecs.push_back('{0, 32'd7,         32'hFFFF_FF9C, 32'h0000_0000, 1'b0, "div_7_m100"});
    vecs.push_back('{0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2"});

    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset.result", data_result, 32'd0);
    check("reset.exception", {31'd0, data_exception}, 32'd0);
    check("reset.rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.adder_a", adder_a, 32'd0);
    check("reset.adder_b", adder_b, 32'd0);
    check("reset.adder_cin", {31'd0, adder_cin}, 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      start_op(vecs[i].is_mul, !vecs[i].is_mul, vecs[i].a, vecs[i].b);
      wait_rdy(vecs[i].is_mul ? MUL_LAT : DIV_LAT, vecs[i].res, vecs[i].exc, vecs[i].name);
    end

    for (int n = 0; n < 20; n++) begin
      rm = $urandom_range(0, 1) == 1;
      ra = (n % 3 == 0) ? 32'($signed(16'($urandom))) : $urandom;
      rb = (n % 4 == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      if (n % 5 == 2) rb = 32'($signed(-int'($urandom_range(1, 9))));
      model(rm, ra, rb, er, ee);
      start_op(rm, !rm, ra, rb);
      wait_rdy(rm ? MUL_LAT : DIV_LAT, er, ee, rm ? "rand_mul" : "rand_div");
    end

    // DIV aborted by a MULT started at edge 10: RDY only at edge 43
    start_op(0, 1, 32'd1000, 32'd3);
    no_rdy = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0) no_rdy = 1'b0;
    end
    check("abort.early_rdy", {31'd0, no_rdy}, 32'd1);
    start_op(1, 0, 32'd5, 32'd6);
    wait_rdy(MUL_LAT, 32'd30, 1'b0, "abort_mul");

    // both starts together: multiply is performed
    start_op(1, 1, 32'd5, 32'd6);
    wait_rdy(MUL_LAT, 32'd30, 1'b0, "both_start");

    // asynchronous reset in the middle of a multiply
    start_op(1, 0, 32'd7, 32'hFFFF_FFFD);
    for (int k = 1; k <= 15; k++) @(negedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset.result", data_result, 32'd0);
    check("async_reset.busy", {31'd0, busy}, 32'd0);
    check("async_reset.rdy", {31'd0, data_resultRDY}, 32'd0);
    check("async_reset.adder_b", adder_b, 32'd0);
    check("async_reset.adder_a", adder_a, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    no_rdy  = 1'b1;
    no_busy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0) no_rdy = 1'b0;
      if (busy !== 1'b0) no_busy = 1'b0;
    end
    check("after_reset.no_rdy", {31'd0, no_rdy}, 32'd1);
    check("after_reset.idle", {31'd0, no_busy}, 32'd1);
    model(1, 32'h0000_1234, 32'hFFFF_FFFB, er, ee);
    start_op(1, 0, 32'h0000_1234, 32'hFFFF_FFFB);
    wait_rdy(MUL_LAT, er, ee, "post_reset_mul");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Iterative signed multiply/divide sequencer for the multdiv unit.
- Owns no adder: it drives one external shared 32-bit CLA adder (sum = a + b + cin, with carry out) once per cycle.
- Multiply uses radix-2 Booth; divide uses restoring division on magnitudes.
- Results return to the pipeline's multdiv stall logic via a one-cycle ready pulse.

Parameters:
- WIDTH, 32, operand/result width; must match the shared adder width.
- MUL_CYCLES, 33, start edge to data_resultRDY for MULT.
- DIV_CYCLES, 36, start edge to data_resultRDY for DIV.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ctrl_MULT  in  1  start-multiply pulse, sampled each edge
- ctrl_DIV  in  1  start-divide pulse, sampled each edge
- data_operandA  in  32  multiplicand/dividend; sampled only on a start edge
- data_operandB  in  32  multiplier/divisor; sampled only on a start edge
- adder_a  out  32  shared adder operand A
- adder_b  out  32  shared adder operand B
- adder_cin  out  1  shared adder carry in
- adder_sum  in  32  shared adder result, same cycle (combinational)
- adder_cout  in  1  shared adder carry out
- data_result  out  32  low 32 bits of product, or signed quotient
- data_exception  out  1  valid with data_resultRDY
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  high while not IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers 0. Takes effect immediately, including mid-operation; no ready pulse follows.
- Start: the edge where ctrl_MULT or ctrl_DIV is high latches both operands and enters MUL or DIV_NEGA.
  - Both high: MULT wins.
  - Start while busy: aborts the current operation and restarts with the new operands; no ready pulse for the aborted one.
- States: IDLE, MUL, DIV_NEGA, DIV_NEGB, DIV, DIV_FIX, DONE.
- MUL (32 cycles, 6-bit iteration counter):
  - Register {ACC[31:0], Q[31:0], q_1} is initialised to {0, B, 0}; M = A.
  - {Q[0], q_1} = 01: adder_a = ACC, adder_b = M, adder_cin = 0.
  - {Q[0], q_1} = 10: adder_a = ACC, adder_b = ~M, adder_cin = 1.
  - Otherwise: adder_b = 0, adder_cin = 0.
  - True 33rd bit: ext = adder_a[31] ^ adder_b[31] ^ adder_cout. This keeps M = 0x80000000 exact.
  - Arithmetic right shift of {ext, adder_sum, Q, q_1} by 1 into {ACC, Q, q_1}.
- DIV_NEGA / DIV_NEGB: one cycle each; the adder forms |A| then |B|.
  - Negative operand: adder_b = ~x, cin = 1.
  - Non-negative operand: adder_b = x, adder_a = 0, cin = 0.
  - Magnitudes are treated as unsigned (0x80000000 is preserved).
- DIV (32 cycles):
  - Each cycle: R' = {R[30:0], Dd[31]}, Dd <<= 1.
  - Adder computes R' + ~|B| + 1.
  - adder_cout = 1: R = adder_sum, quotient bit 1. Otherwise R = R', quotient bit 0.
  - Quotient bits shift into Dd[0].
- DIV_FIX: one cycle.
  - If sign(A) ^ sign(B), the quotient is negated via the adder (~Q + 1); otherwise it passes through (+0).
  - Remainder is discarded.
- DONE: one cycle.
  - data_resultRDY = 1 and data_result, data_exception valid.
  - Next state IDLE, unless a start is sampled in the same edge.
  - data_result and data_exception hold until the next start or reset; data_resultRDY returns to 0.
- Exceptions:
  - MULT: data_exception = 1 iff product[63:31] is not all-equal; data_result = product[31:0] regardless.
  - DIV: B = 0 gives data_exception = 1 and data_result = 0, at the normal latency of 36.
  - DIV: A = 0x80000000 with B = 0xFFFFFFFF gives data_exception = 1 and data_result = 0x80000000.
- Fixed latency: data_resultRDY is high exactly MUL_CYCLES/DIV_CYCLES edges after the start edge.
- Adder ports in IDLE/DONE: all 0.

Decomposition:
- Shared package multdiv_pkg:
  - state enum (7 states, 3-bit encoding)
  - WIDTH
  - iteration count constant 32
  - MUL_CYCLES, DIV_CYCLES
  - Booth pair encodings
- One natural sub-module: booth_select. Combinational; maps {Q[0], q_1} and M to adder_b/adder_cin and ext.
- The adder stays external so it can be shared.

Test Plan:
- MULT 7 × -3 → RDY at edge 33; result 0xFFFFFFEB; exception 0; busy high edges 1..32.
- MULT 0x80000000 × 1 → result 0x80000000, exception 0. MULT 0x80000000 × -1 → result 0x80000000, exception 1. MULT 0x00010000 × 0x00010000 → result 0, exception 1.
- DIV -100 / 7 → RDY at edge 36; result 0xFFFFFFF2 (-14); exception 0. DIV 100 / 0 → result 0, exception 1 at edge 36.
- DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception 1. DIV 0x80000000 / 2 → 0xC0000000, exception 0.
- DIV started, then MULT 5 × 6 pulsed at edge 10 → no RDY for the DIV; RDY at edge 43 with result 30. ctrl_MULT and ctrl_DIV both high → multiply performed.
- reset_n low at edge 15 of a MULT → outputs 0 asynchronously; no RDY afterwards; a new MULT after release completes normally in 33 cycles.
